// File: rtl/ycr1_wb_arb_pkg.sv
// Shared types and arbitration helper for the imem/dmem Wishbone arbiter.
`timescale 1ns/1ps
package ycr1_wb_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_IMEM, ARB_DMEM} ycr1_wb_arb_state_e;
  typedef enum logic {ARB_M_IMEM, ARB_M_DMEM} ycr1_wb_arb_mst_e;

  localparam int unsigned ARB_SEL_W = 4;

  // Round-robin pick from idle: a lone requester wins, a tie goes to the
  // master that was not served last.
  function automatic ycr1_wb_arb_state_e arb_pick(
    input logic             imem_req,
    input logic             dmem_req,
    input ycr1_wb_arb_mst_e last_gnt
  );
    ycr1_wb_arb_state_e pick;
    pick = ARB_IDLE;
    if (imem_req && dmem_req) begin
      if (last_gnt == ARB_M_IMEM) pick = ARB_DMEM;
      else                        pick = ARB_IMEM;
    end else if (imem_req) begin
      pick = ARB_IMEM;
    end else if (dmem_req) begin
      pick = ARB_DMEM;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ycr1_wb_arb_timer.sv
// Grant-duration watchdog. Counts cycles spent in a grant state and flags
// the cycle that is the TIMEOUT_CYCLES-th one of the grant. Used only when
// YCR1_WB_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module ycr1_wb_arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic start,
  input  logic stop,
  output logic expired
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  // Counter holds the number of grant cycles already completed, so the
  // grant's first cycle sees zero and the terminal cycle sees CNT_LAST.
  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
    end else if (stop) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (run_q && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timer state register.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  assign expired = run_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ycr1_wb_mem_arb.sv
// Two-master (imem, dmem) to one-slave Wishbone arbiter with a registered
// round-robin grant. Optional grant timeout: define YCR1_WB_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module ycr1_wb_mem_arb
  import ycr1_wb_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,

  input  logic                 wbd_imem_stb_i,
  input  logic                 wbd_imem_we_i,
  input  logic [AW-1:0]        wbd_imem_adr_i,
  input  logic [DW-1:0]        wbd_imem_dat_i,
  input  logic [ARB_SEL_W-1:0] wbd_imem_sel_i,
  output logic [DW-1:0]        wbd_imem_dat_o,
  output logic                 wbd_imem_ack_o,
  output logic                 wbd_imem_err_o,

  input  logic                 wbd_dmem_stb_i,
  input  logic                 wbd_dmem_we_i,
  input  logic [AW-1:0]        wbd_dmem_adr_i,
  input  logic [DW-1:0]        wbd_dmem_dat_i,
  input  logic [ARB_SEL_W-1:0] wbd_dmem_sel_i,
  output logic [DW-1:0]        wbd_dmem_dat_o,
  output logic                 wbd_dmem_ack_o,
  output logic                 wbd_dmem_err_o,

  output logic                 wbs_stb_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_we_o,
  output logic [AW-1:0]        wbs_adr_o,
  output logic [DW-1:0]        wbs_dat_o,
  output logic [ARB_SEL_W-1:0] wbs_sel_o,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i
);

  ycr1_wb_arb_state_e state_q, state_d;
  ycr1_wb_arb_mst_e   last_gnt_q, last_gnt_d;

  logic slv_resp;
  logic rsp_ack;
  logic rsp_err;
  logic tmo_expired;

  // A zero timeout would fire before any slave could answer.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_cfg_chk
    $error("ycr1_wb_mem_arb: TIMEOUT_CYCLES must be at least 1");
  end

  assign slv_resp = wbs_ack_i | wbs_err_i;

  // Next-state: pick a master from idle; leave a grant on any response
  // (recording who was served) or on an abort (history left unchanged).
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      ARB_IDLE: begin
        state_d = arb_pick(wbd_imem_stb_i, wbd_dmem_stb_i, last_gnt_q);
      end
      ARB_IMEM: begin
        if (slv_resp || tmo_expired) begin
          state_d    = ARB_IDLE;
          last_gnt_d = ARB_M_IMEM;
        end else if (!wbd_imem_stb_i) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_DMEM: begin
        if (slv_resp || tmo_expired) begin
          state_d    = ARB_IDLE;
          last_gnt_d = ARB_M_DMEM;
        end else if (!wbd_dmem_stb_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Grant and round-robin history registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= ARB_IDLE;
      last_gnt_q <= ARB_M_DMEM;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // Slave request mux, steered by the registered grant so the slave never
  // sees a request from a master that was not granted at the last edge.
  always_comb begin
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    case (state_q)
      ARB_IMEM: begin
        wbs_stb_o = wbd_imem_stb_i;
        wbs_cyc_o = wbd_imem_stb_i;
        wbs_we_o  = wbd_imem_we_i;
        wbs_adr_o = wbd_imem_adr_i;
        wbs_dat_o = wbd_imem_dat_i;
        wbs_sel_o = wbd_imem_sel_i;
      end
      ARB_DMEM: begin
        wbs_stb_o = wbd_dmem_stb_i;
        wbs_cyc_o = wbd_dmem_stb_i;
        wbs_we_o  = wbd_dmem_we_i;
        wbs_adr_o = wbd_dmem_adr_i;
        wbs_dat_o = wbd_dmem_dat_i;
        wbs_sel_o = wbd_dmem_sel_i;
      end
      default: ;
    endcase
  end

  // Error beats ack when both arrive; a timeout only counts when the slave
  // stays silent in the terminal cycle.
  assign rsp_ack = wbs_ack_i & ~wbs_err_i;
  assign rsp_err = wbs_err_i | (tmo_expired & ~wbs_ack_i);

  assign wbd_imem_ack_o = (state_q == ARB_IMEM) & rsp_ack;
  assign wbd_imem_err_o = (state_q == ARB_IMEM) & rsp_err;
  assign wbd_dmem_ack_o = (state_q == ARB_DMEM) & rsp_ack;
  assign wbd_dmem_err_o = (state_q == ARB_DMEM) & rsp_err;

  // Read data is broadcast; it is qualified by the per-master ack.
  assign wbd_imem_dat_o = wbs_dat_i;
  assign wbd_dmem_dat_o = wbs_dat_i;

`ifdef YCR1_WB_ARB_TIMEOUT_EN
  logic tmo_start;
  logic tmo_stop;

  assign tmo_start = (state_q == ARB_IDLE) && (state_d != ARB_IDLE);
  assign tmo_stop  = (state_q != ARB_IDLE) && (state_d == ARB_IDLE);

  ycr1_wb_arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .start   (tmo_start),
    .stop    (tmo_stop),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

endmodule

// File: tb/tb_ycr1_wb_mem_arb.sv
// Directed bench for ycr1_wb_mem_arb with a transaction-level reference
// model compared every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_ycr1_wb_mem_arb;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        i_stb = 1'b0, i_we = 1'b0, d_stb = 1'b0, d_we = 1'b0;
  logic [31:0] i_adr = '0, i_dat = '0, d_adr = '0, d_dat = '0;
  logic [3:0]  i_sel = '0, d_sel = '0;
  logic [31:0] i_dat_o, d_dat_o;
  logic        i_ack_o, i_err_o, d_ack_o, d_err_o;
  logic        s_stb, s_cyc, s_we;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_i = '0;
  logic        s_ack_i = 1'b0, s_err_i = 1'b0;

  always #5 clk = ~clk;

  ycr1_wb_mem_arb #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk(clk), .wb_rst(wb_rst),
    .wbd_imem_stb_i(i_stb), .wbd_imem_we_i(i_we), .wbd_imem_adr_i(i_adr),
    .wbd_imem_dat_i(i_dat), .wbd_imem_sel_i(i_sel), .wbd_imem_dat_o(i_dat_o),
    .wbd_imem_ack_o(i_ack_o), .wbd_imem_err_o(i_err_o),
    .wbd_dmem_stb_i(d_stb), .wbd_dmem_we_i(d_we), .wbd_dmem_adr_i(d_adr),
    .wbd_dmem_dat_i(d_dat), .wbd_dmem_sel_i(d_sel), .wbd_dmem_dat_o(d_dat_o),
    .wbd_dmem_ack_o(d_ack_o), .wbd_dmem_err_o(d_err_o),
    .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc), .wbs_we_o(s_we), .wbs_adr_o(s_adr),
    .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_dat_i(s_dat_i),
    .wbs_ack_i(s_ack_i), .wbs_err_i(s_err_i)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Master request state (owned by the main process).
  logic        i_pend = 1'b0, d_pend = 1'b0;
  logic        ip_we, dp_we;
  logic [31:0] ip_adr, ip_dat, dp_adr, dp_dat;
  logic [3:0]  ip_sel, dp_sel;
  logic        i_rsp = 1'b0, d_rsp = 1'b0;

  // Slave behaviour: respond when stb has been seen slv_lat+1 cycles.
  int          slv_lat = 0;
  int          slv_mode = 0;   // 0 ack, 1 err, 2 ack+err together
  int          slv_cnt = 0;
  logic        late_ack = 1'b0;
  logic [31:0] slv_data = 32'h0;

  // Reference model: who owns the slave, who was served last, grant age.
  int   m_own = 0;             // 0 none, 1 imem, 2 dmem
  int   m_last = 2;
  int   m_cyc = 0;
  logic chk_en = 1'b0;

  // Observations.
  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } req_t;
  req_t glog[$];
  logic prev_stb = 1'b0;
  int   i_ack_n = 0, i_err_n = 0, d_ack_n = 0, d_err_n = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic model_tmo();
`ifdef YCR1_WB_ARB_TIMEOUT_EN
    return (m_own != 0) && (m_cyc == TMO);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_gstb();
    if (m_own == 1) return i_stb;
    if (m_own == 2) return d_stb;
    return 1'b0;
  endfunction

  // Expected packed outputs for the current cycle from the model.
  function automatic logic [138:0] model_out();
    logic        stb, we, rack, rerr;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
    if (m_own == 1) begin
      stb = i_stb; we = i_we; adr = i_adr; dat = i_dat; sel = i_sel;
    end else if (m_own == 2) begin
      stb = d_stb; we = d_we; adr = d_adr; dat = d_dat; sel = d_sel;
    end
    rack = s_ack_i && !s_err_i;
    rerr = s_err_i || (model_tmo() && !s_ack_i);
    return {stb, stb, we, adr, dat, sel,
            (m_own == 1) && rack, (m_own == 1) && rerr,
            (m_own == 2) && rack, (m_own == 2) && rerr,
            s_dat_i, s_dat_i};
  endfunction

  // One clock cycle: advance model at the edge, drive masters, drive slave,
  // compare at the falling edge.
  task automatic tick();
    logic tmo, gstb;
    @(posedge clk);
    tmo  = model_tmo();
    gstb = model_gstb();
    if (wb_rst) begin
      m_own = 0; m_last = 2; m_cyc = 0;
    end else if (m_own == 0) begin
      if (i_stb && d_stb) m_own = (m_last == 1) ? 2 : 1;
      else if (i_stb)     m_own = 1;
      else if (d_stb)     m_own = 2;
      m_cyc = (m_own != 0) ? 1 : 0;
    end else if (s_ack_i || s_err_i || tmo) begin
      m_last = m_own; m_own = 0; m_cyc = 0;
    end else if (!gstb) begin
      m_own = 0; m_cyc = 0;
    end else begin
      m_cyc++;
    end
    #1;
    if (i_pend && i_rsp) i_pend = 1'b0;
    if (d_pend && d_rsp) d_pend = 1'b0;
    i_stb = i_pend; i_we = i_pend & ip_we;
    i_adr = i_pend ? ip_adr : '0; i_dat = i_pend ? ip_dat : '0; i_sel = i_pend ? ip_sel : '0;
    d_stb = d_pend; d_we = d_pend & dp_we;
    d_adr = d_pend ? dp_adr : '0; d_dat = d_pend ? dp_dat : '0; d_sel = d_pend ? dp_sel : '0;
    #1;
    if (s_stb) slv_cnt++; else slv_cnt = 0;
    s_ack_i = late_ack || (s_stb && (slv_cnt == slv_lat + 1) && (slv_mode != 1));
    s_err_i = s_stb && (slv_cnt == slv_lat + 1) && (slv_mode != 0);
    s_dat_i = (s_ack_i) ? slv_data : 32'h0;
    @(negedge clk);
    if (chk_en)
      chk("cycle_outputs",
          {s_stb, s_cyc, s_we, s_adr, s_dat, s_sel, i_ack_o, i_err_o, d_ack_o, d_err_o, i_dat_o, d_dat_o},
          model_out());
    i_rsp = i_ack_o | i_err_o;
    d_rsp = d_ack_o | d_err_o;
    if (i_ack_o) i_ack_n++;
    if (i_err_o) i_err_n++;
    if (d_ack_o) d_ack_n++;
    if (d_err_o) d_err_n++;
    if (s_stb && !prev_stb) glog.push_back({s_adr, s_we, s_dat, s_sel});
    prev_stb = s_stb;
  endtask

  task automatic issue_i(input logic [31:0] a, input logic w, input logic [31:0] dt, input logic [3:0] sl);
    i_pend = 1'b1; i_rsp = 1'b0; ip_adr = a; ip_we = w; ip_dat = dt; ip_sel = sl;
  endtask

  task automatic issue_d(input logic [31:0] a, input logic w, input logic [31:0] dt, input logic [3:0] sl);
    d_pend = 1'b1; d_rsp = 1'b0; dp_adr = a; dp_we = w; dp_dat = dt; dp_sel = sl;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while ((i_pend || d_pend) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, {i_pend, d_pend}, 2'b00);
  endtask

  task automatic clr_counts();
    i_ack_n = 0; i_err_n = 0; d_ack_n = 0; d_err_n = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    // Reset and reset-state check.
    wb_rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    wb_rst = 1'b0;
    chk("reset_state", {s_stb, s_cyc, i_ack_o, i_err_o, d_ack_o, d_err_o}, 6'b0);

    // Single imem read, slave answers two cycles after its stb.
    clr_counts();
    slv_lat = 2; slv_mode = 0; slv_data = 32'hDEAD_BEEF;
    issue_i(32'h0000_0100, 1'b0, 32'h0, 4'hF);
    tick(); chk("t1_stb_before_grant", s_stb, 1'b0);
    tick(); chk("t1_stb_rise", s_stb, 1'b1);
    chk("t1_adr", s_adr, 32'h0000_0100);
    tick(); chk("t1_no_ack_yet", i_ack_o, 1'b0);
    tick(); chk("t1_ack", i_ack_o, 1'b1);
    chk("t1_rdata", i_dat_o, 32'hDEAD_BEEF);
    tick(); chk("t1_bubble", s_stb, 1'b0);
    chk("t1_dmem_ack_quiet", d_ack_n, 0);

    // Simultaneous requests after reset, four rounds.
    wb_rst = 1'b1; tick(); wb_rst = 1'b0;
    slv_lat = 0; slv_data = 32'h0BAD_F00D;
    glog.delete();
    for (int r = 0; r < 4; r++) begin
      issue_i(32'h0000_1000 + r, 1'b0, 32'h0, 4'hF);
      issue_d(32'h0000_2000 + r, 1'b0, 32'h0, 4'hF);
      wait_idle(30, "t2_round_done");
    end
    chk("t2_n_grants", glog.size(), 8);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ea;
      ea = ((k % 2) == 0) ? (32'h0000_1000 + k / 2) : (32'h0000_2000 + k / 2);
      chk($sformatf("t2_grant_%0d", k), glog[k].adr, ea);
    end

    // dmem write after an imem access; afterwards a tie must go to imem.
    issue_i(32'h0000_0300, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t3_pre_done");
    clr_counts();
    slv_lat = 1;
    glog.delete();
    issue_d(32'h0000_0200, 1'b1, 32'h1234_5678, 4'b0011);
    wait_idle(20, "t3_wr_done");
    chk("t3_slave_req", glog[0], {32'h0000_0200, 1'b1, 32'h1234_5678, 4'b0011});
    chk("t3_dmem_ack", d_ack_n, 1);
    chk("t3_imem_ack_quiet", i_ack_n, 0);
    slv_lat = 0;
    glog.delete();
    issue_i(32'h0000_0310, 1'b0, 32'h0, 4'hF);
    issue_d(32'h0000_0320, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t3_tie_done");
    chk("t3_tie_first_imem", glog[0].adr, 32'h0000_0310);

    // Slave raises ack and err together.
    clr_counts();
    slv_mode = 2;
    issue_i(32'h0000_0400, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t4_done");
    chk("t4_err_cnt", i_err_n, 1);
    chk("t4_ack_cnt", i_ack_n, 0);
    tick(); chk("t4_idle_after", s_stb, 1'b0);
    slv_mode = 0;
    glog.delete();
    issue_i(32'h0000_0410, 1'b0, 32'h0, 4'hF);
    issue_d(32'h0000_0420, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t4_tie_done");
    chk("t4_tie_first_dmem", glog[0].adr, 32'h0000_0420);

    // Reset pulsed while an imem grant waits for a slave that never answers.
    issue_i(32'h0000_0500, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t5_pre_done");
    slv_lat = 10000;
    issue_i(32'h0000_0510, 1'b0, 32'h0, 4'hF);
    tick(); tick(); tick();
    chk("t5_granted", s_stb, 1'b1);
    wb_rst = 1'b1; i_pend = 1'b0;
    tick(); chk("t5_rst_drop", s_stb, 1'b0);
    wb_rst = 1'b0; late_ack = 1'b1; slv_data = 32'h5555_AAAA;
    tick(); chk("t5_late_ack_ignored", {i_ack_o, i_err_o, d_ack_o, d_err_o}, 4'b0);
    late_ack = 1'b0; slv_lat = 0;
    glog.delete();
    issue_i(32'h0000_0520, 1'b0, 32'h0, 4'hF);
    issue_d(32'h0000_0530, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t5_tie_done");
    chk("t5_tie_first_imem", glog[0].adr, 32'h0000_0520);

    // Abort: dmem drops stb before any response; history must stay imem.
    issue_i(32'h0000_0600, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t6_pre_done");
    slv_lat = 10000;
    issue_d(32'h0000_0610, 1'b0, 32'h0, 4'hF);
    tick(); tick(); tick();
    chk("t6_dmem_granted", {s_stb, s_adr}, {1'b1, 32'h0000_0610});
    d_pend = 1'b0;
    tick();
    slv_lat = 0;
    glog.delete();
    issue_i(32'h0000_0620, 1'b0, 32'h0, 4'hF);
    issue_d(32'h0000_0630, 1'b0, 32'h0, 4'hF);
    wait_idle(20, "t6_tie_done");
    chk("t6_tie_first_dmem", glog[0].adr, 32'h0000_0630);

`ifdef YCR1_WB_ARB_TIMEOUT_EN
    // Grant timeout with a silent slave.
    begin
      int g, err_at, n;
      g = 0; err_at = 0; n = 0;
      clr_counts();
      slv_lat = 10000;
      issue_i(32'h0000_0700, 1'b0, 32'h0, 4'hF);
      while (i_pend && n < 30) begin
        tick();
        n++;
        if (s_stb) g++;
        if (i_err_o && err_at == 0) err_at = g;
      end
      chk("t7_done", i_pend, 1'b0);
      chk("t7_err_cycle", err_at, TMO);
      chk("t7_err_cnt", i_err_n, 1);
      tick(); chk("t7_idle_after", s_stb, 1'b0);
      slv_lat = 0;
    end
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
